// File: rtl/reg_bank_seq.sv
// 32x32 MIPS register bank with a post-reset clear/SP-load sweep and registered read ports.
// Define REG_BYPASS_EN to forward same-edge write data to a matching read port.
module reg_bank_seq #(
  parameter int          SP_REG  = 29,
  parameter logic [31:0] SP_INIT = 32'd227
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic        ready
);
  localparam int NPORT = 2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state, state_nxt;
  logic [4:0]               idx;
  logic [31:0]              rf [32];
  logic                     we, wr_run;
  logic [4:0]               wa;
  logic [31:0]              wd;
  logic [NPORT-1:0][4:0]    raddr;
  logic [NPORT-1:0][31:0]   rdata_nxt, rdata_q;

  assign raddr = {ReadReg2, ReadReg1};

  // Single array write port, shared by the sweep and normal writes.
  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    wr_run    = 1'b0;
    wa        = WriteReg;
    wd        = WriteData;
    case (state)
      CLEAR: begin
        we = reset;
        wa = idx;
        wd = (idx == 5'(SP_REG)) ? SP_INIT : 32'd0;
        if (idx == 5'd31) state_nxt = RUN;
      end
      RUN: begin
        wr_run = RegWrite && (WriteReg != 5'd0);
        we     = reset && wr_run;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Reads are zero outside RUN and for $0; otherwise the pre-write array value.
  always_comb begin
    rdata_nxt = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (state == RUN && raddr[p] != 5'd0) begin
        rdata_nxt[p] = rf[raddr[p]];
`ifdef REG_BYPASS_EN
        if (wr_run && WriteReg == raddr[p]) rdata_nxt[p] = WriteData;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= CLEAR;
      idx     <= '0;
      ready   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      rdata_q <= rdata_nxt;
      if (state == CLEAR) begin
        if (idx == 5'd31) ready <= 1'b1;
        else              idx   <= idx + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) rf[wa] <= wd;
  end

  assign ReadData1 = rdata_q[0];
  assign ReadData2 = rdata_q[1];
endmodule

// File: tb/tb_reg_bank_seq.sv
// Directed bench for reg_bank_seq: reset sweep timing, read/write, $0, same-edge hazard, reset restart.
module tb_reg_bank_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg, ReadReg1, ReadReg2;
  logic [31:0] WriteData, ReadData1, ReadData2;
  logic        ready;
  int          nchk = 0;
  int          nerr = 0;

  reg_bank_seq dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present indices before the next edge, sample data after it.
  task automatic rd(input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] ea, input logic [31:0] eb, input string tag);
    ReadReg1 = a;
    ReadReg2 = b;
    @(negedge clk);
    chk({tag, "_p1"}, ReadData1, ea);
    chk({tag, "_p2"}, ReadData2, eb);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite  = 1'b1;
    WriteReg  = a;
    WriteData = d;
    @(negedge clk);
    RegWrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = 5'd29; ReadReg2 = 5'd29;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rd1", ReadData1, 32'd0);
    chk("rst_rd2", ReadData2, 32'd0);

    // Sweep: ready low for 31 edges, high after the 32nd; stray write at sweep cycle 10.
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 11) begin
        RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hAAAA5555;
      end
      @(negedge clk);
      RegWrite = 1'b0;
      chk($sformatf("sweep_ready_%0d", i), {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
      if (i == 16) chk("sweep_rd_held", ReadData1, 32'd0);
    end

    rd(5'd29, 5'd5, 32'd227, 32'd0, "init_29_5");
    rd(5'd31, 5'd29, 32'd0, 32'd227, "init_31_29");
    rd(5'd3, 5'd0, 32'd0, 32'd0, "sweep_wr_ignored");

    wr(5'd8, 32'hDEADBEEF);
    rd(5'd8, 5'd8, 32'hDEADBEEF, 32'hDEADBEEF, "wr8");

    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0, 32'd0, 32'd0, "wr0");

    wr(5'd31, 32'hCAFEF00D);
    rd(5'd31, 5'd8, 32'hCAFEF00D, 32'hDEADBEEF, "wr31");

    // Same-edge write and read of $9.
    ReadReg1 = 5'd9; ReadReg2 = 5'd29;
    wr(5'd9, 32'h12345678);
`ifdef REG_BYPASS_EN
    chk("hazard9_p1", ReadData1, 32'h12345678);
`else
    chk("hazard9_p1", ReadData1, 32'd0);
`endif
    chk("hazard9_p2", ReadData2, 32'd227);
    rd(5'd29, 5'd9, 32'd227, 32'h12345678, "after9");

    // Bypass must not forward a write to $0.
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    wr(5'd0, 32'h5A5A5A5A);
    chk("hazard0_p1", ReadData1, 32'd0);
    chk("hazard0_p2", ReadData2, 32'd0);

    // Reset mid-sweep at cycle 20 restarts the full sweep.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_ready_pre", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_rd1", ReadData1, 32'd0);
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      chk($sformatf("resweep_ready_%0d", i), {31'd0, ready}, (i == 32) ? 32'd1 : 32'd0);
    end
    rd(5'd29, 5'd8, 32'd227, 32'd0, "resweep_29_8");
    rd(5'd31, 5'd9, 32'd0, 32'd0, "resweep_31_9");

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/reg_bank_seq.md
# reg_bank_seq

Synchronous 32 x 32-bit general-purpose register bank for the multicycle MIPS datapath, sitting directly downstream of the destination-register selector. Its write address comes from the selected destination register (rt, rd, $29, $31 or rs), and its two registered read ports feed the A/B operand latches. After reset it runs a one-register-per-cycle initialisation sweep that clears every register and loads the stack pointer, then signals `ready`.

## Interface
- `SP_REG`, default 29: index of the stack-pointer register.
- `SP_INIT`, default 227: value loaded into `SP_REG` by the initialisation sweep.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset. It is sampled only on the rising edge of `clk`.
- `RegWrite`  in  1  write enable.
- `WriteReg`  in  5  destination index, driven by the destination-register selector.
- `WriteData`  in  32  write data.
- `ReadReg1`  in  5  read port 1 index (rs).
- `ReadReg2`  in  5  read port 2 index (rt).
- `ReadData1`  out  32  registered read data, port 1.
- `ReadData2`  out  32  registered read data, port 2.
- `ready`  out  1  high once the initialisation sweep has completed.

## Operation
- Storage is 32 words of 32 bits. Register $0 always reads 0, and writes to it are discarded.
- The block has two states: CLEAR and RUN.
- Any edge with `reset` = 0 does the following:
  - state <= CLEAR, sweep index <= 0;
  - `ready` <= 0, `ReadData1` <= 0, `ReadData2` <= 0.
  - This applies in any state, including mid-sweep, and the sweep restarts from index 0.
- CLEAR, on each edge with `reset` = 1:
  - reg[idx] <= (idx == `SP_REG`) ? `SP_INIT` : 0;
  - idx <= idx + 1.
  - At idx = 31 the write completes, state <= RUN and `ready` <= 1.
  - `RegWrite` is ignored in CLEAR.
  - `ReadData1`/`ReadData2` are held at 0.
- RUN, on each edge:
  - If `RegWrite` = 1 and `WriteReg` != 0: reg[`WriteReg`] <= `WriteData`.
  - `ReadData1` <= (`ReadReg1` == 0) ? 0 : reg[`ReadReg1`]; `ReadData2` is computed the same way.
- The sweep index is 5 bits and does not wrap. Leaving CLEAR at idx = 31 is the only exit.
- Both read ports may address the same register, and each returns the same value.

## Timing
- Read latency is 1 cycle: the index is presented before edge n and the data is valid after edge n.
- Write latency is 1 cycle: data written at edge n is readable via the stored array from edge n+1 onward.
- Same-edge write and read of the same nonzero index:
  - the result is governed by the Configuration section below;
  - without bypass, the read returns the old value.
- After `reset` returns high, `ready` rises after exactly 32 edges, and the first RUN-state read captures at the 33rd edge.
- Reset values of the outputs: `ReadData1` = 0, `ReadData2` = 0, `ready` = 0.
- Array contents are not defined until the sweep completes.

## Configuration
- `REG_BYPASS_EN` defined:
  - In RUN, if `RegWrite` = 1, `WriteReg` != 0 and `WriteReg` == `ReadRegN`, then `ReadDataN` <= `WriteData` at the same edge (write-to-read forwarding).
- `REG_BYPASS_EN` undefined:
  - `ReadDataN` <= the pre-write stored value at that edge.
  - The new value appears on the next read.
- In both builds, index 0 always reads 0.

## Test plan
- Hold `reset` = 0 for 2 cycles, then release. `ready` must be 0 for 32 edges and 1 after the 32nd. Reading $29 returns 227, and reading $5 and $31 returns 0.
- In RUN, write $8 = 0xDEADBEEF, then on the next cycle read `ReadReg1` = 8 and `ReadReg2` = 8. Both ports must return 0xDEADBEEF one cycle later.
- In RUN, write $0 = 0xFFFFFFFF, then read $0 on both ports. Both must return 0.
- Write $9 = 0x12345678 while reading $9 at the same edge:
  - with `REG_BYPASS_EN`, the read returns 0x12345678;
  - without it, the read returns the prior value 0, and the next read returns 0x12345678.
- Drive `RegWrite` = 1 with `WriteReg` = 3, `WriteData` = 0xAAAA5555 during sweep cycle 10. After `ready`, $3 must read 0.
- Pull `reset` low at sweep cycle 20, then release. `ready` must stay 0 for a full 32 further edges, and afterwards $29 must read 227.
